// File: rtl/alu_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_ctrl_if
//  Brief    : Bundles the command, response and ALU-side buses of the
//             ALU command sequencer. The controller uses the slave modport;
//             the command source / response consumer / ALU use master.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_cmd_ctrl_if #(
  parameter int CNT_W = 8
);
  // command port
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_fun;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  // ALU side
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_fun;
  logic [7:0]       alu_out;
  logic             alu_arith;
  logic             alu_logic;
  logic             alu_cmp;
  logic             alu_shift;
  // response port
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [3:0]       rsp_flags;
  logic             rsp_err;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  cmd_valid, cmd_fun, cmd_a, cmd_b,
    input  alu_out, alu_arith, alu_logic, alu_cmp, alu_shift,
    input  rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_fun,
    output rsp_valid, rsp_data, rsp_flags, rsp_err, op_count
  );

  modport master (
    output cmd_valid, cmd_fun, cmd_a, cmd_b,
    output alu_out, alu_arith, alu_logic, alu_cmp, alu_shift,
    output rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_fun,
    input  rsp_valid, rsp_data, rsp_flags, rsp_err, op_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_ctrl
//  Brief    : Single-outstanding command sequencer in front of the 8-bit
//             flagged ALU. Screens illegal commands, holds operands for a
//             settle window, samples result + class flags, returns them
//             over a valid/ready response port and counts completions.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_ctrl #(
  parameter int SETTLE_CYC = 1,  // 1..15
  parameter int CNT_W      = 8   // must match the interface CNT_W
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  alu_cmd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_CYC = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] C_FUN_IDLE = 4'b1111;

  state_t     state;
  logic [3:0] settle_cnt;
  logic       illegal;

  // Commands the ALU cannot execute: reserved code, or division by zero.
  assign illegal = (bus.cmd_fun == 4'b1111) ||
                   ((bus.cmd_fun == 4'b0011) && (bus.cmd_b == 8'd0));

  // Sequencer FSM; every output is a register so the ALU sees glitch-free inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      settle_cnt    <= 4'd0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 8'd0;
      bus.rsp_flags <= 4'd0;
      bus.rsp_err   <= 1'b0;
      bus.op_count  <= '0;
      bus.alu_a     <= 8'd0;
      bus.alu_b     <= 8'd0;
      bus.alu_fun   <= C_FUN_IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            if (illegal) begin
              // Answer directly; the ALU keeps its idle pattern.
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= 8'd0;
              bus.rsp_flags <= 4'd0;
              state         <= RESP;
            end else begin
              // The ALU input registers double as the command latch.
              bus.alu_a   <= bus.cmd_a;
              bus.alu_b   <= bus.cmd_b;
              bus.alu_fun <= bus.cmd_fun;
              settle_cnt  <= 4'd0;
              state       <= DRIVE;
            end
          end
        end

        DRIVE: begin
          if (settle_cnt == C_LAST_CYC) begin
            bus.rsp_data  <= bus.alu_out;
            bus.rsp_flags <= {bus.alu_arith, bus.alu_logic,
                              bus.alu_cmp, bus.alu_shift};
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.alu_a     <= 8'd0;
            bus.alu_b     <= 8'd0;
            bus.alu_fun   <= C_FUN_IDLE;
            state         <= RESP;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.op_count  <= bus.op_count + 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.alu_a     <= 8'd0;
          bus.alu_b     <= 8'd0;
          bus.alu_fun   <= C_FUN_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
